// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state encoding, funct3 codes and op decode helpers for muldiv_seq
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   function automatic logic is_div(input logic [2:0] f);
      return f[2];
   endfunction

   function automatic logic a_signed(input logic [2:0] f);
      return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
   endfunction

   // MULHSU deliberately treats rs2 as unsigned
   function automatic logic b_signed(input logic [2:0] f);
      return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     m,
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // acc holds {partial product, remaining multiplier} or {remainder, remaining dividend}
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      shifted  = acc[2*WIDTH-1:WIDTH-1];
      diff     = shifted - {1'b0, m};
      acc_next = {sum, acc[WIDTH-1:1]};
      if (div) begin
         if (!diff[WIDTH]) begin
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer with fixed latency
// Optional MULDIV_FASTPATH_EN: divide-by-zero, signed overflow and zero multiplies skip CALC.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNTW-1:0]  LAST    = CNTW'(WIDTH - 1);

   state_t               state, state_next;
   logic [CNTW-1:0]      cnt;
   logic [2*WIDTH-1:0]   acc, acc_step;
   logic [WIDTH-1:0]     mag, dividend;
   logic [2:0]           op;
   logic                 neg_a, neg_b, div_zero, div_ovf;

   logic                 in_div, sgn_a, sgn_b, in_zero, in_dz, in_ovf, fast, accept;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic                 op_div;

   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo, rem, fixed;

   always_comb begin
      in_div  = is_div(funct3);
      sgn_a   = a_signed(funct3) && srca[WIDTH-1];
      sgn_b   = b_signed(funct3) && srcb[WIDTH-1];
      abs_a   = sgn_a ? -srca : srca;
      abs_b   = sgn_b ? -srcb : srcb;
      in_zero = !in_div && ((srca == '0) || (srcb == '0));
      in_dz   = in_div && (srcb == '0);
      in_ovf  = in_div && !funct3[0] && (srca == MIN_NEG) && (srcb == '1);
`ifdef MULDIV_FASTPATH_EN
      fast    = in_zero || in_dz || in_ovf;
`else
      fast    = 1'b0;
`endif
   end

   assign accept = (state == IDLE) && start && !flush;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = fast ? FIX : CALC;
         CALC: begin
            if (flush) begin
               state_next = IDLE;
            end else if (cnt == LAST) begin
               state_next = FIX;
            end
         end
         FIX:     state_next = flush ? IDLE : DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op       <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
         dividend <= '0;
         mag      <= '0;
         acc      <= '0;
         cnt      <= '0;
      end else if (accept) begin
         op       <= funct3;
         neg_a    <= sgn_a;
         neg_b    <= sgn_b;
         div_zero <= in_dz;
         div_ovf  <= in_ovf;
         dividend <= srca;
         mag      <= in_div ? abs_b : abs_a;
         cnt      <= '0;
         // a zero multiply operand clears the accumulator so the product is 0 on any path
         if (in_div) begin
            acc <= {{WIDTH{1'b0}}, abs_a};
         end else if (in_zero) begin
            acc <= '0;
         end else begin
            acc <= {{WIDTH{1'b0}}, abs_b};
         end
      end else if (state == CALC) begin
         acc <= acc_step;
         cnt <= cnt + CNTW'(1);
      end
   end

   assign op_div = is_div(op);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div      (op_div),
      .acc      (acc),
      .m        (mag),
      .acc_next (acc_step)
   );

   always_comb begin
      prod = (neg_a ^ neg_b) ? -acc : acc;
      quo  = acc[WIDTH-1:0];
      rem  = acc[2*WIDTH-1:WIDTH];
      if (neg_a ^ neg_b) quo = -quo;
      if (neg_a) rem = -rem;
      if (div_zero) begin
         quo = '1;
         rem = dividend;
      end else if (div_ovf) begin
         quo = dividend;
         rem = '0;
      end
      case (op)
         F3_MUL:                        fixed = prod[WIDTH-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  fixed = prod[2*WIDTH-1:WIDTH];
         F3_DIV, F3_DIVU:               fixed = quo;
         default:                       fixed = rem;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result <= '0;
      end else if ((state == FIX) && !flush) begin
         result <= fixed;
      end
   end

   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   assign stall = start | busy;

endmodule
